// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - pipeline stage types: stage state encoding and per-stage payload bundles
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [3:0]  alu_op;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] pc4;
    } idex_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [31:0] alu_out;
        logic [31:0] store_val;
        logic [31:0] pc4;
    } exmem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_wen;
        logic [31:0] wb_val;
    } memwb_t;

    localparam int unsigned IFID_W  = $bits(ifid_t);
    localparam int unsigned IDEX_W  = $bits(idex_t);
    localparam int unsigned EXMEM_W = $bits(exmem_t);
    localparam int unsigned MEMWB_W = $bits(memwb_t);

    function automatic logic [1:0] occ_of(input pipe_state_t st);
        case (st)
            PS_FULL: occ_of = 2'd1;
            PS_SKID: occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised valid/ready pipeline stage register with hold, flush and optional skid entry
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        SKID      = 1,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic push;
    logic pop;

    assign push = in_valid & in_ready & en;
    assign pop  = out_valid & out_ready & en;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t       state_q, state_d;
            logic [DATA_W-1:0] main_q, main_d;
            logic [DATA_W-1:0] skid_q, skid_d;
            logic              in_ready_q, in_ready_d;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = PS_EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end else begin
                    case (state_q)
                        PS_EMPTY: begin
                            if (push) begin
                                state_d = PS_FULL;
                                main_d  = in_data;
                            end
                        end
                        PS_FULL: begin
                            if (push && pop) begin
                                main_d = in_data;
                            end else if (push) begin
                                state_d = PS_SKID;
                                skid_d  = in_data;
                            end else if (pop) begin
                                state_d = PS_EMPTY;
                            end
                        end
                        PS_SKID: begin
                            // The older payload always drains through main first.
                            if (pop) begin
                                state_d = PS_FULL;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = PS_EMPTY;
                    endcase
                end
                in_ready_d = (state_d != PS_SKID);
            end

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    state_q    <= PS_EMPTY;
                    main_q     <= RESET_VAL;
                    skid_q     <= RESET_VAL;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    main_q     <= main_d;
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != PS_EMPTY);
            assign out_data  = main_q;
            assign occ       = occ_of(state_q);
        end else begin : g_single
            logic              valid_q, valid_d;
            logic [DATA_W-1:0] main_q, main_d;

            always_comb begin
                valid_d = valid_q;
                main_d  = main_q;
                if (flush) begin
                    valid_d = 1'b0;
                    main_d  = RESET_VAL;
                end else if (push) begin
                    valid_d = 1'b1;
                    main_d  = in_data;
                end else if (pop) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    valid_q <= 1'b0;
                    main_q  <= RESET_VAL;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end

            assign in_ready  = !valid_q | (out_ready & en);
            assign out_valid = valid_q;
            assign out_data  = main_q;
            assign occ       = {1'b0, valid_q};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg, skid and single-entry variants side by side
module tb_pipe_stage_reg;

    localparam logic [31:0] RV = 32'h0BAD_F00D;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        rdy1, ov1, rdy0, ov0;
    logic [31:0] od1, od0;
    logic [1:0]  oc1, oc0;

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .RESET_VAL(RV)) u_skid (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occ(oc1)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .RESET_VAL(RV)) u_single (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occ(oc0)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Model: each stage is a bounded FIFO; "hold" is what out_data shows when empty.
    logic [31:0] q1[$];
    logic [31:0] q0[$];
    logic [31:0] hold1 = RV;
    logic [31:0] hold0 = RV;
    logic [31:0] got0[$];
    bit pu1, po1, pu0, po0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST || flush) begin
            q1.delete();
            q0.delete();
            hold1 = RV;
            hold0 = RV;
        end else begin
            pu1 = in_valid && en && (q1.size() < 2);
            po1 = out_ready && en && (q1.size() > 0);
            pu0 = in_valid && en && (q0.size() == 0 || out_ready);
            po0 = out_ready && en && (q0.size() > 0);
            if (po1) hold1 = q1.pop_front();
            if (pu1) q1.push_back(in_data);
            if (po0) hold0 = q0.pop_front();
            if (pu0) q0.push_back(in_data);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        check("skid.out_valid", 32'(ov1), 32'(q1.size() > 0));
        check("skid.out_data", od1, (q1.size() > 0) ? q1[0] : hold1);
        check("skid.occ", 32'(oc1), 32'(q1.size()));
        check("skid.in_ready", 32'(rdy1), 32'(q1.size() < 2));
        check("single.out_valid", 32'(ov0), 32'(q0.size() > 0));
        check("single.out_data", od0, (q0.size() > 0) ? q0[0] : hold0);
        check("single.occ", 32'(oc0), 32'(q0.size()));
        check("single.in_ready", 32'(rdy0), 32'(q0.size() == 0 || (out_ready && en)));
        if (nRST && !flush && ov0 && out_ready && en) got0.push_back(od0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int  sent;
    int  cyc;
    bit  accept;

    initial begin
        repeat (2) tick();
        @(negedge CLK);
        check("rst.skid.out_valid", 32'(ov1), 32'd0);
        check("rst.skid.occ", 32'(oc1), 32'd0);
        check("rst.skid.in_ready", 32'(rdy1), 32'd1);
        check("rst.skid.out_data", od1, RV);
        check("rst.single.out_data", od0, RV);
        tick();
        nRST = 1'b1;
        en   = 1'b1;

        // First push from empty
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge CLK);
        check("lat.skid.out_valid", 32'(ov1), 32'd1);
        check("lat.skid.out_data", od1, 32'hDEAD_BEEF);
        check("lat.skid.occ", 32'(oc1), 32'd1);
        check("lat.single.out_data", od0, 32'hDEAD_BEEF);
        repeat (2) tick();

        // Fill main and skid, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        in_valid = 1'b0;
        @(negedge CLK);
        check("fill.skid.occ", 32'(oc1), 32'd2);
        check("fill.skid.in_ready", 32'(rdy1), 32'd0);
        check("fill.skid.head", od1, 32'h1);
        out_ready = 1'b1;
        tick();
        @(negedge CLK);
        check("drain.skid.second", od1, 32'h2);
        tick();
        @(negedge CLK);
        check("drain.skid.empty", 32'(ov1), 32'd0);

        // Full-rate stream
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 32'h10 + 32'(i);
            tick();
            @(negedge CLK);
            check("stream.skid.out_data", od1, 32'h10 + 32'(i));
            check("stream.skid.occ", 32'(oc1), 32'd1);
            check("stream.skid.in_ready", 32'(rdy1), 32'd1);
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Stall with en low
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5;
        tick();
        in_data = 32'h77; out_ready = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge CLK);
            check("stall.skid.out_data", od1, 32'hA5);
            check("stall.skid.occ", 32'(oc1), 32'd1);
            check("stall.single.out_data", od0, 32'hA5);
        end
        en = 1'b1; in_valid = 1'b0;
        repeat (3) tick();

        // Flush from SKID state beats a same-cycle push
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h3;
        tick();
        in_data = 32'h4;
        tick();
        in_data = 32'h5; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge CLK);
        check("flush.skid.occ", 32'(oc1), 32'd0);
        check("flush.skid.out_valid", 32'(ov1), 32'd0);
        check("flush.skid.out_data", od1, RV);
        check("flush.skid.in_ready", 32'(rdy1), 32'd1);
        check("flush.single.out_valid", 32'(ov0), 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        check("flush.skid.no_ghost", 32'(ov1), 32'd0);

        // Single-entry stage under toggling backpressure
        got0.delete();
        sent = 0; cyc = 0;
        in_valid = 1'b1;
        while (sent < 8 && cyc < 100) begin
            out_ready = (cyc % 2 == 0);
            in_data = 32'h20 + 32'(sent);
            #1;
            if (ov0) check("toggle.single.in_ready", 32'(rdy0), 32'(out_ready));
            accept = rdy0;
            @(posedge CLK);
            #1;
            if (accept) sent++;
            cyc++;
        end
        check("toggle.sent_all", 32'(sent), 32'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        check("toggle.count", 32'(got0.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got0.size()) check("toggle.order", got0[i], 32'h20 + 32'(i));
        end

        // Asynchronous reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h99;
        repeat (2) tick();
        #2;
        nRST = 1'b0;
        #1;
        check("arst.skid.out_valid", 32'(ov1), 32'd0);
        check("arst.skid.occ", 32'(oc1), 32'd0);
        check("arst.skid.in_ready", 32'(rdy1), 32'd1);
        check("arst.skid.out_data", od1, RV);
        check("arst.single.out_valid", 32'(ov0), 32'd0);
        in_valid = 1'b0;
        tick();
        nRST = 1'b1;
        in_valid = 1'b1; in_data = 32'h42; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge CLK);
        check("arst.skid.repush", od1, 32'h42);
        check("arst.skid.reocc", 32'(oc1), 32'd1);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
